// File: rtl/mont_modexp_ctrl_pkg.sv
// Shared widths, state encodings and constants for the Montgomery modexp sequencer.
package mont_modexp_ctrl_pkg;

  localparam int unsigned WID    = 256;
  localparam int unsigned CNTWID = 8;

  typedef enum logic [2:0] {
    TOP_IDLE = 3'd0,
    TOP_CONV = 3'd1,
    TOP_SQR  = 3'd2,
    TOP_MUL  = 3'd3,
    TOP_FROM = 3'd4
  } top_state_e;

  typedef enum logic [1:0] {
    OP_ISSUE = 2'd0,
    OP_WLO   = 2'd1,
    OP_WHI   = 2'd2
  } op_state_e;

  localparam logic [WID-1:0] ONE = {{(WID-1){1'b0}}, 1'b1};

endpackage

// File: rtl/mont_op_seq.sv
// One Montgomery product handshake: issue when the multiplier is idle, see done drop,
// then capture on done rising.
module mont_op_seq
  import mont_modexp_ctrl_pkg::*;
#(
  parameter int unsigned PWID = WID
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_go,
  input  logic [PWID-1:0] i_x,
  input  logic [PWID-1:0] i_y,
  input  logic            i_mm_done,
  output logic [PWID-1:0] o_mm_a,
  output logic [PWID-1:0] o_mm_b,
  output logic            o_mm_start,
  output logic            o_cap_c,
  output logic            o_busy
);

  op_state_e       r_state;
  op_state_e       w_state_nxt;
  logic            w_issue;
  logic            r_mm_start;
  logic            r_busy;
  logic [PWID-1:0] r_mm_a;
  logic [PWID-1:0] r_mm_b;

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= OP_ISSUE;
    else        r_state <= w_state_nxt;
  end

  // WLO must see done low before WHI accepts done high, so a stale level is never a completion.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    o_cap_c     = 1'b0;
    case (r_state)
      OP_ISSUE: if (i_go && i_mm_done) begin
        w_issue     = 1'b1;
        w_state_nxt = OP_WLO;
      end
      OP_WLO:   if (!i_mm_done) w_state_nxt = OP_WHI;
      OP_WHI:   if (i_mm_done) begin
        o_cap_c     = 1'b1;
        w_state_nxt = OP_ISSUE;
      end
      default:  w_state_nxt = OP_ISSUE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_mm_start <= 1'b0;
      r_busy     <= 1'b0;
      r_mm_a     <= '0;
      r_mm_b     <= '0;
    end else begin
      r_mm_start <= w_issue;
      r_busy     <= (w_state_nxt != OP_ISSUE);
      if (w_issue) begin
        r_mm_a <= i_x;
        r_mm_b <= i_y;
      end
    end
  end

  assign o_mm_a     = r_mm_a;
  assign o_mm_b     = r_mm_b;
  assign o_mm_start = r_mm_start;
  assign o_busy     = r_busy;

endmodule

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply modexp driving an external Montgomery multiplier,
// with conversion into and out of the Montgomery domain.
module mont_modexp_ctrl
  import mont_modexp_ctrl_pkg::*;
#(
  parameter int unsigned PWID    = WID,
  parameter int unsigned PCNTWID = CNTWID
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [PWID-1:0] i_base,
  input  logic [PWID-1:0] i_expo,
  input  logic [PWID-1:0] i_m,
  input  logic [PWID-1:0] i_r2,
  input  logic [PWID-1:0] i_rone,
  output logic [PWID-1:0] o_res,
  output logic            o_done,
  output logic [PWID-1:0] o_mm_a,
  output logic [PWID-1:0] o_mm_b,
  output logic            o_mm_start,
  input  logic            i_mm_done,
  input  logic [PWID-1:0] i_mm_r
);

  top_state_e         r_state;
  top_state_e         w_state_nxt;
  logic [PWID-1:0]    r_base;
  logic [PWID-1:0]    r_expo;
  logic [PWID-1:0]    r_r2;
  logic [PWID-1:0]    r_acc;
  logic [PWID-1:0]    r_bm;
  logic [PWID-1:0]    r_res;
  logic [PCNTWID-1:0] r_idx;
  logic               r_done;
  logic               w_go;
  logic [PWID-1:0]    w_x;
  logic [PWID-1:0]    w_y;
  logic               w_cap;
  logic               w_op_busy;
  logic               w_last;
  logic               w_unused_m;

  // The modulus is held by the multiplier itself; only the port is kept here.
  assign w_unused_m = ^i_m;
  assign w_last     = (r_idx == '0);
  assign w_go       = (r_state != TOP_IDLE) && !w_op_busy;

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= TOP_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x         = '0;
    w_y         = '0;
    case (r_state)
      TOP_IDLE: if (i_start) w_state_nxt = TOP_CONV;
      TOP_CONV: begin
        w_x = r_base;
        w_y = r_r2;
        if (w_cap) w_state_nxt = TOP_SQR;
      end
      TOP_SQR: begin
        w_x = r_acc;
        w_y = r_acc;
        if (w_cap) w_state_nxt = r_expo[r_idx] ? TOP_MUL : (w_last ? TOP_FROM : TOP_SQR);
      end
      TOP_MUL: begin
        w_x = r_acc;
        w_y = r_bm;
        if (w_cap) w_state_nxt = w_last ? TOP_FROM : TOP_SQR;
      end
      TOP_FROM: begin
        w_x = r_acc;
        w_y = PWID'(ONE);
        if (w_cap) w_state_nxt = TOP_IDLE;
      end
      default: w_state_nxt = TOP_IDLE;
    endcase
  end

  // Operand latch, accumulator, bit index and result capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_base <= '0;
      r_expo <= '0;
      r_r2   <= '0;
      r_acc  <= '0;
      r_bm   <= '0;
      r_res  <= '0;
      r_idx  <= '0;
      r_done <= 1'b1;
    end else begin
      case (r_state)
        TOP_IDLE: if (i_start) begin
          r_base <= i_base;
          r_expo <= i_expo;
          r_r2   <= i_r2;
          r_acc  <= i_rone;
          r_idx  <= PCNTWID'(PWID - 1);
          r_done <= 1'b0;
        end
        TOP_CONV: if (w_cap) r_bm <= i_mm_r;
        TOP_SQR: if (w_cap) begin
          r_acc <= i_mm_r;
          if (!r_expo[r_idx] && !w_last) r_idx <= r_idx - PCNTWID'(1);
        end
        TOP_MUL: if (w_cap) begin
          r_acc <= i_mm_r;
          if (!w_last) r_idx <= r_idx - PCNTWID'(1);
        end
        TOP_FROM: if (w_cap) begin
          r_res  <= i_mm_r;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  mont_op_seq #(.PWID(PWID)) u_op (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_go       (w_go),
    .i_x        (w_x),
    .i_y        (w_y),
    .i_mm_done  (i_mm_done),
    .o_mm_a     (o_mm_a),
    .o_mm_b     (o_mm_b),
    .o_mm_start (o_mm_start),
    .o_cap_c    (w_cap),
    .o_busy     (w_op_busy)
  );

  assign o_res  = r_res;
  assign o_done = r_done;

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Scoreboard bench for mont_modexp_ctrl at WID=8, m=13, with a variable-latency multiplier model.
module tb_mont_modexp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base, expo, m, r2, rone;
  logic [7:0] res;
  logic       done;
  logic [7:0] mm_a, mm_b;
  logic       mm_start;
  logic       mm_done = 1'b1;
  logic [7:0] mm_r = 8'h00;

  typedef struct {
    logic [7:0] res;
    int         nprod;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   prod_cnt = 0;
  int   proto_err = 0;
  int   lat_lo = 1;
  int   lat_hi = 20;
  bit   slow_drop = 1'b0;

  mont_modexp_ctrl #(.PWID(8), .PCNTWID(3)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_start    (start),
    .i_base     (base),
    .i_expo     (expo),
    .i_m        (m),
    .i_r2       (r2),
    .i_rone     (rone),
    .o_res      (res),
    .o_done     (done),
    .o_mm_a     (mm_a),
    .o_mm_b     (mm_b),
    .o_mm_start (mm_start),
    .i_mm_done  (mm_done),
    .i_mm_r     (mm_r)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b);
    int rinv = 0;
    for (int k = 1; k < 13; k++) if ((256 * k) % 13 == 1) rinv = k;
    return 8'((int'(a) * int'(b) * rinv) % 13);
  endfunction

  function automatic int modexp(input int b, input int e);
    int r = 1;
    for (int k = 7; k >= 0; k--) begin
      r = (r * r) % 13;
      if (e[k]) r = (r * b) % 13;
    end
    return r;
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  // Multiplier model: accepts start only while idle, optional slow drop, latency lat_lo..lat_hi.
  bit         pending = 1'b0;
  int         drop_left = 0;
  int         busy_left = 0;
  logic [7:0] pa, pb;
  always @(posedge clk) begin
    if (mm_start) begin
      if (!mm_done || pending) proto_err++;
      else begin
        prod_cnt++;
        pa = mm_a;
        pb = mm_b;
        pending = 1'b1;
        drop_left = slow_drop ? 3 : 0;
        busy_left = $urandom_range(lat_hi, lat_lo);
        if (drop_left == 0) mm_done <= 1'b0;
      end
    end else if (pending) begin
      if (drop_left > 0) begin
        drop_left--;
        if (drop_left == 0) mm_done <= 1'b0;
      end else begin
        busy_left--;
        if (busy_left == 0) begin
          mm_done <= 1'b1;
          mm_r    <= mont(pa, pb);
          pending = 1'b0;
        end
      end
    end
  end

  task automatic run_op(input logic [7:0] b, input logic [7:0] e, input bit glitch);
    exp_t x;
    int   p0, p1;
    x.res   = 8'(modexp(int'(b), int'(e)));
    x.nprod = 2 + 8 + $countones(e);
    sb_q.push_back(x);
    @(negedge clk);
    start = 1'b1; base = b; expo = e; r2 = 8'd3; rone = 8'd9;
    p0 = prod_cnt;
    @(negedge clk);
    start = 1'b0; base = ~b; expo = ~e; r2 = 8'hff; rone = 8'h55;
    chk_eq("done_drop", 32'(done), 32'd0);
    for (int c = 0; c < 20000; c++) begin
      if (glitch && c >= 2 && c < 10) begin
        start = 1'b1; base = 8'd1; expo = 8'd1;
      end else start = 1'b0;
      @(negedge clk);
      if (done) break;
    end
    start = 1'b0;
    chk_eq("done_rise", 32'(done), 32'd1);
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      chk_eq("res", 32'(res), 32'(x.res));
      chk_eq("nprod", 32'(prod_cnt - p0), 32'(x.nprod));
    end
    p1 = prod_cnt;
    repeat (5) @(negedge clk);
    chk_eq("done_hold", 32'(done), 32'd1);
    chk_eq("res_hold", 32'(res), 32'(x.res));
    chk_eq("idle_prod", 32'(prod_cnt - p1), 32'd0);
    chk_eq("proto", 32'(proto_err), 32'd0);
    r2 = 8'd3; rone = 8'd9;
  endtask

  initial begin
    int p0;
    rst_n = 1'b0; start = 1'b0; base = '0; expo = '0; m = 8'd13; r2 = 8'd3; rone = 8'd9;
    repeat (3) @(negedge clk);
    chk_eq("rst_done", 32'(done), 32'd1);
    chk_eq("rst_res", 32'(res), 32'd0);
    chk_eq("rst_mm_start", 32'(mm_start), 32'd0);
    chk_eq("rst_mm_a", 32'(mm_a), 32'd0);
    chk_eq("rst_mm_b", 32'(mm_b), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd2, 8'd5, 1'b0);
    run_op(8'd7, 8'd0, 1'b0);
    run_op(8'd12, 8'd255, 1'b0);

    // Abort mid-operation while the multiplier is still busy.
    lat_lo = 20; lat_hi = 20;
    @(negedge clk);
    start = 1'b1; base = 8'd5; expo = 8'd200;
    @(negedge clk);
    start = 1'b0;
    p0 = prod_cnt;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (prod_cnt >= p0 + 5 && !mm_done) break;
    end
    chk_eq("abort_mm_busy", 32'(mm_done), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_eq("abort_done", 32'(done), 32'd1);
    chk_eq("abort_res", 32'(res), 32'd0);
    chk_eq("abort_mm_start", 32'(mm_start), 32'd0);
    chk_eq("abort_mm_a", 32'(mm_a), 32'd0);
    rst_n = 1'b1;
    lat_lo = 1; lat_hi = 20;
    run_op(8'd3, 8'd2, 1'b0);

    slow_drop = 1'b1;
    run_op(8'd5, 8'd11, 1'b0);
    slow_drop = 1'b0;

    run_op(8'd6, 8'd77, 1'b1);

    for (int k = 0; k < 3; k++)
      run_op(8'($urandom_range(12, 0)), 8'($urandom_range(255, 0)), 1'b0);

    chk_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
